// File: rtl/rst_seq_gen_pkg.sv
// Shared state encoding and default timing for the reset sequencer.
// Defaults assume a 50 MHz clk.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_RELEASE  = 2'd1,
        S_WAIT_BTN = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    localparam int DEF_DB_CYCLES   = 500000;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 4;
    localparam int DEF_NSTAGE      = 3;
    localparam int DEF_CNT_W       = 20;

endpackage

// File: rtl/rst_seq_gen_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer plus level debouncer.
// Accepts a level change after DB_CYCLES stable differing cycles; no flow control.
module btn_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                dout <= ~dout;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rst_seq_gen.sv
// Merges power-on, pushbutton and software resets into NSTAGE ordered reset outputs.
// Minimum HOLD_CYCLES assertion, then one stage released every STAGE_GAP cycles.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              sw_req,
    output logic              sw_ack,
    output logic [NSTAGE-1:0] rst_stage,
    output logic              rst_any,
    output logic              busy
);

    localparam logic [NSTAGE-1:0] ALL_ON    = '1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic             db_btn;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db (
        .clk  (clk),
        .rst  (rst),
        .din  (btn),
        .dout (db_btn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_HOLD;
            cnt       <= '0;
            rst_stage <= ALL_ON;
            busy      <= 1'b1;
            sw_ack    <= 1'b0;
        end else begin
            sw_ack <= 1'b0;
            case (state)
                S_HOLD: begin
                    if (db_btn) begin
                        state     <= S_WAIT_BTN;
                        cnt       <= '0;
                        rst_stage <= ALL_ON;
                    end else if (cnt == HOLD_LAST) begin
                        cnt       <= '0;
                        rst_stage <= ALL_ON << 1;
                        if (NSTAGE == 1) begin
                            state <= S_RUN;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (db_btn) begin
                        state     <= S_WAIT_BTN;
                        cnt       <= '0;
                        rst_stage <= ALL_ON;
                    end else if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        rst_stage <= rst_stage << 1;
                        // Last asserted stage drops on this edge: sequence complete.
                        if ((rst_stage << 1) == '0) begin
                            state <= S_RUN;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_BTN: begin
                    rst_stage <= ALL_ON;
                    busy      <= 1'b1;
                    if (!db_btn) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    // A press outranks a software request, but the request is still acked.
                    if (db_btn) begin
                        state     <= S_WAIT_BTN;
                        cnt       <= '0;
                        rst_stage <= ALL_ON;
                        busy      <= 1'b1;
                        sw_ack    <= sw_req;
                    end else if (sw_req) begin
                        state     <= S_HOLD;
                        cnt       <= '0;
                        rst_stage <= ALL_ON;
                        busy      <= 1'b1;
                        sw_ack    <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_HOLD;
                    cnt       <= '0;
                    rst_stage <= ALL_ON;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

    assign rst_any = |rst_stage;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen with a short debounce window (DB_CYCLES=8).
module tb_rst_seq_gen;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       sw_req;
    logic       sw_ack;
    logic [2:0] rst_stage;
    logic       rst_any;
    logic       busy;

    int nvec    = 0;
    int nerr    = 0;
    int ack_cnt = 0;
    int viol    = 0;
    bit mon     = 1'b0;

    rst_seq_gen #(
        .DB_CYCLES   (8),
        .HOLD_CYCLES (16),
        .STAGE_GAP   (4),
        .NSTAGE      (3),
        .CNT_W       (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .sw_req    (sw_req),
        .sw_ack    (sw_ack),
        .rst_stage (rst_stage),
        .rst_any   (rst_any),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        ack_cnt += int'(sw_ack);
        if (mon && (rst_any || busy)) viol++;
    endtask

    // Positioned 'pre' edges after the edge that entered S_HOLD with count 0.
    task automatic run_seq(input string tag, input int pre);
        repeat (15 - pre) step();
        chk({tag, "_e15_stage"}, 32'(rst_stage), 32'h7);
        step();
        chk({tag, "_e16_stage"}, 32'(rst_stage), 32'h6);
        repeat (3) step();
        chk({tag, "_e19_stage"}, 32'(rst_stage), 32'h6);
        step();
        chk({tag, "_e20_stage"}, 32'(rst_stage), 32'h4);
        repeat (3) step();
        chk({tag, "_e23_stage"}, 32'(rst_stage), 32'h4);
        chk({tag, "_e23_busy"},  32'(busy),      32'h1);
        step();
        chk({tag, "_e24_stage"}, 32'(rst_stage), 32'h0);
        chk({tag, "_e24_busy"},  32'(busy),      32'h0);
        chk({tag, "_e24_any"},   32'(rst_any),   32'h0);
    endtask

    initial begin
        rst    = 1'b1;
        btn    = 1'b0;
        sw_req = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_stage", 32'(rst_stage), 32'h7);
        chk("rst_any",   32'(rst_any),   32'h1);
        chk("rst_busy",  32'(busy),      32'h1);
        chk("rst_ack",   32'(sw_ack),    32'h0);

        // Power-on sequence
        rst     = 1'b0;
        ack_cnt = 0;
        run_seq("por", 0);
        chk("por_no_ack", 32'(ack_cnt), 32'h0);

        // Bounce rejection: pulses of 3..7 cycles never reach 8 stable cycles
        mon = 1'b1;
        for (int i = 3; i <= 7; i++) begin
            btn = 1'b1;
            repeat (i) step();
            btn = 1'b0;
            repeat (i) step();
        end
        repeat (12) step();
        mon = 1'b0;
        chk("bounce_viol",  32'(viol),      32'h0);
        chk("bounce_stage", 32'(rst_stage), 32'h0);

        // Clean press held 40 cycles
        btn = 1'b1;
        repeat (10) step();
        chk("press_e10_stage", 32'(rst_stage), 32'h0);
        step();
        chk("press_e11_stage", 32'(rst_stage), 32'h7);
        chk("press_e11_busy",  32'(busy),      32'h1);
        chk("press_e11_state", 32'(dut.state), 32'h2);
        repeat (29) step();
        chk("press_e40_stage", 32'(rst_stage), 32'h7);
        btn = 1'b0;
        repeat (10) step();
        chk("rel_e10_state", 32'(dut.state), 32'h2);
        step();
        chk("rel_e11_state", 32'(dut.state), 32'h0);
        chk("rel_e11_stage", 32'(rst_stage), 32'h7);
        run_seq("press", 0);

        // Software reset, second request during the sequence is ignored
        ack_cnt = 0;
        sw_req  = 1'b1;
        step();
        sw_req = 1'b0;
        chk("sw_ack_pulse", 32'(sw_ack),    32'h1);
        chk("sw_stage",     32'(rst_stage), 32'h7);
        step();
        chk("sw_ack_drop",  32'(sw_ack),    32'h0);
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        chk("sw2_ack",      32'(sw_ack),    32'h0);
        run_seq("sw", 2);
        chk("sw_ack_count", 32'(ack_cnt), 32'h1);

        // Restart mid-release: debounced press lands while stage 0 is released
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (7) step();
        btn = 1'b1;
        repeat (10) step();
        chk("mid_e17_stage", 32'(rst_stage), 32'h6);
        step();
        chk("mid_e18_stage", 32'(rst_stage), 32'h7);
        chk("mid_e18_state", 32'(dut.state), 32'h2);
        repeat (2) step();
        btn = 1'b0;
        repeat (11) step();
        chk("mid_hold_state", 32'(dut.state), 32'h0);
        run_seq("mid", 0);

        // Button and sw_req in the same S_RUN cycle
        btn = 1'b1;
        repeat (10) step();
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        btn    = 1'b0;
        chk("both_ack",   32'(sw_ack),    32'h1);
        chk("both_state", 32'(dut.state), 32'h2);
        chk("both_stage", 32'(rst_stage), 32'h7);
        repeat (11) step();
        chk("both_hold_state", 32'(dut.state), 32'h0);
        run_seq("both", 0);

        // Async reset between clock edges during S_RELEASE
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (17) step();
        chk("arst_pre_stage", 32'(rst_stage), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stage", 32'(rst_stage), 32'h7);
        chk("arst_busy",  32'(busy),      32'h1);
        chk("arst_any",   32'(rst_any),   32'h1);
        chk("arst_ack",   32'(sw_ack),    32'h0);
        chk("arst_state", 32'(dut.state), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        run_seq("arst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
